kpn_fifo_channel: RTL and testbench

- Parametrised, synchronous KPN channel FIFO. It is the next generation of the team's single-clock token buffer between KPN process modules.
- Adds the following: synchronous reset, explicit full/empty/occupancy outputs, an almost-full threshold, defined simultaneous read/write, and registered read data with a valid strobe.
- One instance sits on every producer→consumer edge of the KPN graph.
- Producers stall on full. Consumers issue rd only when empty is low.

---
 rtl/kpn_pkg.sv | 14 +
 rtl/kpn_fifo_mem.sv | 43 ++++
 rtl/kpn_fifo_channel.sv | 113 +++++++++++
 tb/tb_kpn_fifo_channel.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN channel FIFO: default sizes, token type and depth helper.
package kpn_pkg;

  localparam int KPN_TOKEN_BITS    = 16;
  localparam int KPN_FIFO_ELEMENTS = 5;

  typedef logic [KPN_TOKEN_BITS-1:0] kpn_token_t;

  // Number of token slots addressed by an elements-bit pointer.
  function automatic int kpn_depth(input int elements);
    return 1 << elements;
  endfunction

endpackage

// File: rtl/kpn_fifo_mem.sv
// Token storage for the KPN channel FIFO: one write port and one registered read port.
// The read register is the channel's visible output, so it is cleared by reset and holds
// its value whenever no read is issued.
module kpn_fifo_mem
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER   = KPN_TOKEN_BITS,
  parameter int FIFO_ELEMENTS = KPN_FIFO_ELEMENTS
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     we_i,
  input  logic [FIFO_ELEMENTS-1:0] waddr_i,
  input  logic [BITS_NUMBER-1:0]   wdata_i,
  input  logic                     re_i,
  input  logic [FIFO_ELEMENTS-1:0] raddr_i,
  output logic [BITS_NUMBER-1:0]   rdata_o
);

  localparam int DEPTH = kpn_depth(FIFO_ELEMENTS);

  logic [BITS_NUMBER-1:0] mem_q [DEPTH];
  logic [BITS_NUMBER-1:0] rdata_q;

  // Storage array; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; a read and write to the same slot returns the old token.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/kpn_fifo_channel.sv
// KPN channel FIFO: single-clock token buffer between a producer and a consumer process.
// Pointers, occupancy, flags and accept logic live here; storage is in kpn_fifo_mem.
// All outputs are registered; flags are derived from the next occupancy.
// Optional build macro KPN_FIFO_ERR_EN adds sticky overflow/underflow outputs.
module kpn_fifo_channel
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER       = KPN_TOKEN_BITS,
  parameter int FIFO_ELEMENTS     = KPN_FIFO_ELEMENTS,
  parameter int ALMOST_FULL_LEVEL = kpn_depth(FIFO_ELEMENTS) - 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [BITS_NUMBER-1:0]   entry_1,
  input  logic                     rd,
  output logic [BITS_NUMBER-1:0]   output_1,
  output logic                     output_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [FIFO_ELEMENTS:0]   count
`ifdef KPN_FIFO_ERR_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int                 DEPTH     = kpn_depth(FIFO_ELEMENTS);
  localparam logic [FIFO_ELEMENTS:0] DEPTH_C = (FIFO_ELEMENTS+1)'(DEPTH);
  localparam logic [FIFO_ELEMENTS:0] AF_C    = (FIFO_ELEMENTS+1)'(ALMOST_FULL_LEVEL);

  logic [FIFO_ELEMENTS-1:0] w_ptr_q, w_ptr_d;
  logic [FIFO_ELEMENTS-1:0] r_ptr_q, r_ptr_d;
  logic [FIFO_ELEMENTS:0]   count_q, count_d;
  logic                     full_q, empty_q, almost_full_q;
  logic                     valid_q;
  logic                     rd_acc, wr_acc;

  // A read needs a token present; a write needs space or a read freeing a slot this cycle.
  assign rd_acc = rd & ~empty_q;
  assign wr_acc = wr & (~full_q | rd_acc);

  // Next pointers and occupancy; pointers wrap naturally at the depth.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
    if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;
    count_d = count_q + {{FIFO_ELEMENTS{1'b0}}, wr_acc} - {{FIFO_ELEMENTS{1'b0}}, rd_acc};
  end

  // Control state: pointers, occupancy, registered flags and the read-valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q       <= '0;
      r_ptr_q       <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almost_full_q <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      w_ptr_q       <= w_ptr_d;
      r_ptr_q       <= r_ptr_d;
      count_q       <= count_d;
      full_q        <= (count_d == DEPTH_C);
      empty_q       <= (count_d == '0);
      almost_full_q <= (count_d >= AF_C);
      valid_q       <= rd_acc;
    end
  end

  kpn_fifo_mem #(
    .BITS_NUMBER   (BITS_NUMBER),
    .FIFO_ELEMENTS (FIFO_ELEMENTS)
  ) u_mem (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (wr_acc),
    .waddr_i (w_ptr_q),
    .wdata_i (entry_1),
    .re_i    (rd_acc),
    .raddr_i (r_ptr_q),
    .rdata_o (output_1)
  );

`ifdef KPN_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  // Sticky error flags for dropped writes and reads issued while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr & ~wr_acc) overflow_q  <= 1'b1;
      if (rd & empty_q) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign output_valid = valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign count        = count_q;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed bench for kpn_fifo_channel (depth 4, almost-full level 3) with a queue-based model.
module tb_kpn_fifo_channel;
  import kpn_pkg::*;

  localparam int BITS = 16;
  localparam int FE   = 2;
  localparam int DEP  = 4;
  localparam int AFL  = 3;

  logic            clk = 1'b0;
  logic            reset, wr, rd;
  logic [BITS-1:0] entry_1;
  logic [BITS-1:0] output_1;
  logic            output_valid, full, empty, almost_full;
  logic [FE:0]     count;
`ifdef KPN_FIFO_ERR_EN
  logic            overflow, underflow;
`endif

  kpn_fifo_channel #(
    .BITS_NUMBER       (BITS),
    .FIFO_ELEMENTS     (FE),
    .ALMOST_FULL_LEVEL (AFL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .entry_1      (entry_1),
    .rd           (rd),
    .output_1     (output_1),
    .output_valid (output_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .count        (count)
`ifdef KPN_FIFO_ERR_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  kpn_token_t q[$];
  kpn_token_t m_out;
  logic       m_vld;
  logic       m_ovf, m_udf;
  logic       seen_dead;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, update model at the edge, compare every output after it.
  task automatic step(input logic r, input logic w, input logic rq, input kpn_token_t d);
    logic rd_ok, wr_ok;
    reset = r; wr = w; rd = rq; entry_1 = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_out = '0; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      rd_ok = rq && (q.size() > 0);
      wr_ok = w && ((q.size() < DEP) || rd_ok);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (rq && q.size() == 0) m_udf = 1'b1;
      m_vld = rd_ok;
      if (rd_ok) m_out = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
    chk("output_1",     int'(output_1),     int'(m_out));
    chk("output_valid", int'(output_valid), int'(m_vld));
    chk("count",        int'(count),        q.size());
    chk("empty",        int'(empty),        int'(q.size() == 0));
    chk("full",         int'(full),         int'(q.size() == DEP));
    chk("almost_full",  int'(almost_full),  int'(q.size() >= AFL));
`ifdef KPN_FIFO_ERR_EN
    chk("overflow",     int'(overflow),     int'(m_ovf));
    chk("underflow",    int'(underflow),    int'(m_udf));
`endif
    if (output_valid && output_1 == 16'hDEAD) seen_dead = 1'b1;
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; entry_1 = '0;
    m_out = '0; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; seen_dead = 1'b0;

    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    chk("lit_reset_empty", int'(empty), 1);
    chk("lit_reset_count", int'(count), 0);

    // Reset mid-stream discards tokens
    step(0, 1, 0, 16'h0011);
    step(0, 1, 0, 16'h0022);
    chk("lit_pre_reset_count", int'(count), 2);
    step(1, 0, 0, 16'h0);
    chk("lit_mid_reset_count", int'(count), 0);
    chk("lit_mid_reset_out",   int'(output_1), 0);
    chk("lit_mid_reset_vld",   int'(output_valid), 0);
    step(0, 0, 1, 16'h0);
    chk("lit_rd_after_reset_vld", int'(output_valid), 0);

    // Fill and drain
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, kpn_token_t'(16'hA000 + i));
      if (i == 3) chk("lit_af_at_3", int'(almost_full), 1);
      if (i == 3) chk("lit_not_full_at_3", int'(full), 0);
    end
    chk("lit_full_at_4", int'(full), 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, 16'h0);
      chk("lit_drain_data", int'(output_1), 16'hA000 + i);
      chk("lit_drain_vld",  int'(output_valid), 1);
    end
    chk("lit_drained_empty", int'(empty), 1);

    // Six more tokens crossing the pointer wrap
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, kpn_token_t'(16'hC000 + i));
      step(0, 0, 1, 16'h0);
      chk("lit_wrap_data", int'(output_1), 16'hC000 + i);
    end

    // Full with simultaneous read and write
    for (int i = 1; i <= 4; i++) step(0, 1, 0, kpn_token_t'(16'hD000 + i));
    step(0, 1, 1, 16'hBEEF);
    chk("lit_fullrw_data",  int'(output_1), 16'hD001);
    chk("lit_fullrw_count", int'(count), 4);
    chk("lit_fullrw_full",  int'(full), 1);

    // Write while full is dropped
    step(0, 1, 0, 16'hDEAD);
    chk("lit_ovf_count", int'(count), 4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0);
    chk("lit_beef_last", int'(output_1), 16'hBEEF);
    chk("lit_after_beef_empty", int'(empty), 1);

    // Empty with simultaneous read and write: no bypass
    step(0, 1, 1, 16'h1234);
    chk("lit_emptyrw_vld",   int'(output_valid), 0);
    chk("lit_emptyrw_count", int'(count), 1);
    step(0, 0, 1, 16'h0);
    chk("lit_emptyrw_data", int'(output_1), 16'h1234);

    // Read while empty holds output
    step(0, 0, 1, 16'h0);
    chk("lit_udf_hold", int'(output_1), 16'h1234);
    chk("lit_udf_vld",  int'(output_valid), 0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);

`ifdef KPN_FIFO_ERR_EN
    chk("lit_overflow_sticky",  int'(overflow), 1);
    chk("lit_underflow_sticky", int'(underflow), 1);
    step(1, 0, 0, 16'h0);
    chk("lit_overflow_clr",  int'(overflow), 0);
    chk("lit_underflow_clr", int'(underflow), 0);
`endif

    chk("lit_dead_never_seen", int'(seen_dead), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
